// File: rtl/conv_layer_sched.sv
// Sequencer that streams a source tensor into one conv instance in raster order
// and writes every conv output to its tensor address in a destination buffer.
module conv_layer_sched #(
    parameter int IN_CH   = 8,
    parameter int IN_DIM  = 12,
    parameter int OUT_CH  = 16,
    parameter int OUT_DIM = 4,
    parameter int IDX_W   = 4,
    parameter int POS_W   = 4,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    output logic              busy,
    output logic              done,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [31:0]       src_data,
    output logic              conv_forward,
    output logic [31:0]       conv_in,
    output logic [IDX_W-1:0]  conv_in_idx,
    output logic [POS_W-1:0]  conv_in_x,
    output logic [POS_W-1:0]  conv_in_y,
    output logic              conv_in_valid,
    input  logic              conv_in_rdy,
    output logic              conv_out_rdy,
    input  logic              conv_out_valid,
    input  logic [31:0]       conv_out,
    input  logic [IDX_W-1:0]  conv_out_idx,
    input  logic [POS_W-1:0]  conv_out_x,
    input  logic [POS_W-1:0]  conv_out_y,
    input  logic              dst_ready,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [31:0]       dst_data
);

    localparam logic [IDX_W-1:0]  IN_CH_LAST   = IDX_W'(IN_CH - 1);
    localparam logic [IDX_W-1:0]  OUT_CH_LAST  = IDX_W'(OUT_CH - 1);
    localparam logic [POS_W-1:0]  IN_DIM_LAST  = POS_W'(IN_DIM - 1);
    localparam logic [POS_W-1:0]  OUT_DIM_LAST = POS_W'(OUT_DIM - 1);
    localparam logic [ADDR_W-1:0] IN_DIM_A     = ADDR_W'(IN_DIM);
    localparam logic [ADDR_W-1:0] OUT_DIM_A    = ADDR_W'(OUT_DIM);
    localparam logic [ADDR_W-1:0] IN_AREA      = ADDR_W'(IN_DIM * IN_DIM);
    localparam logic [ADDR_W-1:0] OUT_AREA     = ADDR_W'(OUT_DIM * OUT_DIM);
    localparam logic [ADDR_W:0]   IN_TOTAL     = (ADDR_W+1)'(IN_CH * IN_DIM * IN_DIM);
    localparam logic [ADDR_W:0]   OUT_TOTAL    = (ADDR_W+1)'(OUT_CH * OUT_DIM * OUT_DIM);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic              dir_q;
    logic [IDX_W-1:0]  idx;
    logic [POS_W-1:0]  pos_x;
    logic [POS_W-1:0]  pos_y;
    logic              feed_first;
    logic [31:0]       data_hold;
    logic [ADDR_W:0]   out_cnt;
    logic [ADDR_W:0]   cnt_next;

    logic [IDX_W-1:0]  ch_last;
    logic [POS_W-1:0]  dim_last;
    logic [ADDR_W-1:0] in_dim_w;
    logic [ADDR_W-1:0] in_area;
    logic [ADDR_W-1:0] out_dim_w;
    logic [ADDR_W-1:0] out_area;
    logic [ADDR_W:0]   out_total;

    logic              start_ok;
    logic              in_hs;
    logic              out_hs;
    logic              last_elem;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Backward swaps the roles of the input and output tensor geometries.
    always_comb begin
        if (dir_q) begin
            ch_last   = OUT_CH_LAST;
            dim_last  = OUT_DIM_LAST;
            in_dim_w  = OUT_DIM_A;
            in_area   = OUT_AREA;
            out_dim_w = IN_DIM_A;
            out_area  = IN_AREA;
            out_total = IN_TOTAL;
        end else begin
            ch_last   = IN_CH_LAST;
            dim_last  = IN_DIM_LAST;
            in_dim_w  = IN_DIM_A;
            in_area   = IN_AREA;
            out_dim_w = OUT_DIM_A;
            out_area  = OUT_AREA;
            out_total = OUT_TOTAL;
        end
    end

    assign start_ok  = (state == IDLE) && start;
    assign in_hs     = (state == FEED) && conv_in_rdy;
    assign out_hs    = conv_out_valid && conv_out_rdy;
    assign last_elem = (idx == ch_last) && (pos_y == dim_last) && (pos_x == dim_last);
    assign cnt_next  = out_cnt + (ADDR_W+1)'(out_hs);
    assign rd_addr   = ADDR_W'(idx) * in_area + ADDR_W'(pos_y) * in_dim_w + ADDR_W'(pos_x);
    assign wr_addr   = ADDR_W'(conv_out_idx) * out_area + ADDR_W'(conv_out_y) * out_dim_w
                     + ADDR_W'(conv_out_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: state_next = FEED;
            FEED:  if (conv_in_rdy) state_next = last_elem ? DRAIN : FETCH;
            DRAIN: if (cnt_next >= out_total) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        src_rd        = (state == FETCH);
        src_addr      = (state == FETCH) ? rd_addr : '0;
        conv_in_valid = (state == FEED);
        conv_in       = '0;
        conv_in_idx   = '0;
        conv_in_x     = '0;
        conv_in_y     = '0;
        if (state == FEED) begin
            conv_in     = feed_first ? src_data : data_hold;
            conv_in_idx = idx;
            conv_in_x   = pos_x;
            conv_in_y   = pos_y;
        end
        conv_forward  = ~dir_q;
        conv_out_rdy  = dst_ready && (state != IDLE);
        dst_we        = out_hs;
        dst_addr      = out_hs ? wr_addr : '0;
        dst_data      = out_hs ? conv_out : '0;
    end

    // Source data arrives in the first FEED cycle; it is passed straight through
    // then and held from the register for any further stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= 1'b0;
            idx        <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            feed_first <= 1'b0;
            data_hold  <= '0;
            out_cnt    <= '0;
        end else begin
            feed_first <= (state == FETCH);
            if (feed_first) begin
                data_hold <= src_data;
            end
            if (start_ok) begin
                dir_q   <= dir;
                idx     <= '0;
                pos_x   <= '0;
                pos_y   <= '0;
                out_cnt <= '0;
            end else begin
                if (in_hs && !last_elem) begin
                    if (pos_x == dim_last) begin
                        pos_x <= '0;
                        if (pos_y == dim_last) begin
                            pos_y <= '0;
                            idx   <= idx + 1'b1;
                        end else begin
                            pos_y <= pos_y + 1'b1;
                        end
                    end else begin
                        pos_x <= pos_x + 1'b1;
                    end
                end
                if (out_hs) begin
                    out_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: a behavioural conv/memory environment feeds
// random data; expected reads, inputs and writes are queued and checked by a monitor.
module tb_conv_layer_sched;

    localparam int IDX_W  = 4;
    localparam int POS_W  = 4;
    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              dir;
    logic              busy;
    logic              done;
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_data;
    logic              conv_forward;
    logic [31:0]       conv_in;
    logic [IDX_W-1:0]  conv_in_idx;
    logic [POS_W-1:0]  conv_in_x;
    logic [POS_W-1:0]  conv_in_y;
    logic              conv_in_valid;
    logic              conv_in_rdy;
    logic              conv_out_rdy;
    logic              conv_out_valid;
    logic [31:0]       conv_out;
    logic [IDX_W-1:0]  conv_out_idx;
    logic [POS_W-1:0]  conv_out_x;
    logic [POS_W-1:0]  conv_out_y;
    logic              dst_ready;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [31:0]       dst_data;

    conv_layer_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .busy(busy), .done(done),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .conv_forward(conv_forward), .conv_in(conv_in), .conv_in_idx(conv_in_idx),
        .conv_in_x(conv_in_x), .conv_in_y(conv_in_y), .conv_in_valid(conv_in_valid),
        .conv_in_rdy(conv_in_rdy), .conv_out_rdy(conv_out_rdy),
        .conv_out_valid(conv_out_valid), .conv_out(conv_out), .conv_out_idx(conv_out_idx),
        .conv_out_x(conv_out_x), .conv_out_y(conv_out_y), .dst_ready(dst_ready),
        .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          y;
        int          x;
        logic [31:0] data;
    } in_item_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } out_item_t;

    in_item_t  exp_in[$];
    int        exp_rd[$];
    out_item_t exp_out[$];

    logic [31:0] src_mem [0:2047];

    int n_checks = 0;
    int n_errors = 0;

    bit pass_dir;
    bit model_active;
    bit idle_probe;
    int n_in_total, n_out_total, out_dim;
    int in_cnt, out_emitted;
    int rdy_mode;
    int stall_at;
    int stall_left;
    bit stall_done;
    int n_reads, n_writes, n_done;
    int last_in_idx, last_in_y, last_in_x;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_src_rd"}, 32'(src_rd), 32'd0);
        checkOutput({tag, "_src_addr"}, 32'(src_addr), 32'd0);
        checkOutput({tag, "_in_valid"}, 32'(conv_in_valid), 32'd0);
        checkOutput({tag, "_conv_in"}, conv_in, 32'd0);
        checkOutput({tag, "_in_coord"}, 32'({conv_in_idx, conv_in_y, conv_in_x}), 32'd0);
        checkOutput({tag, "_forward"}, 32'(conv_forward), 32'd1);
        checkOutput({tag, "_dst_we"}, 32'(dst_we), 32'd0);
        checkOutput({tag, "_dst_addr"}, 32'(dst_addr), 32'd0);
        checkOutput({tag, "_dst_data"}, dst_data, 32'd0);
    endtask

    // Environment: source memory with one-cycle read latency, input ready pattern,
    // destination ready stalls, and a conv model emitting the whole output tensor
    // in a scrambled order, never ahead of its share of consumed inputs.
    initial begin : env
        logic              s_rd;
        logic [ADDR_W-1:0] s_addr;
        logic              s_in_hs;
        logic              s_out_hs;
        int                e, c, y, x;
        src_data       = '0;
        conv_in_rdy    = 1'b0;
        dst_ready      = 1'b1;
        conv_out_valid = 1'b0;
        conv_out       = '0;
        conv_out_idx   = '0;
        conv_out_x     = '0;
        conv_out_y     = '0;
        forever begin
            @(negedge clk);
            s_rd     = src_rd;
            s_addr   = src_addr;
            s_in_hs  = conv_in_valid && conv_in_rdy;
            s_out_hs = conv_out_valid && conv_out_rdy;
            @(posedge clk);
            #1;
            if (s_rd) src_data = src_mem[s_addr];
            if (s_in_hs && model_active) in_cnt++;
            if (s_out_hs) begin
                conv_out_valid = 1'b0;
                out_emitted++;
            end
            case (rdy_mode)
                0:       conv_in_rdy = 1'b1;
                1:       conv_in_rdy = !conv_in_rdy;
                default: conv_in_rdy = 1'($urandom_range(1));
            endcase
            if (stall_left > 0) begin
                dst_ready = 1'b0;
                stall_left--;
            end else if (!stall_done && stall_at >= 0 && out_emitted >= stall_at) begin
                stall_done = 1'b1;
                stall_left = 9;
                dst_ready  = 1'b0;
            end else begin
                dst_ready = 1'b1;
            end
            if (idle_probe) begin
                conv_out_valid = 1'b1;
                conv_out       = 32'hdead_beef;
                conv_out_idx   = 4'd3;
                conv_out_x     = 4'd2;
                conv_out_y     = 4'd1;
            end else if (!model_active) begin
                conv_out_valid = 1'b0;
            end else if (!conv_out_valid && out_emitted < n_out_total
                         && in_cnt * n_out_total >= (out_emitted + 1) * n_in_total
                         && $urandom_range(3) != 0) begin
                e = (out_emitted * 97) % n_out_total;
                c = e / (out_dim * out_dim);
                y = (e / out_dim) % out_dim;
                x = e % out_dim;
                conv_out_idx   = IDX_W'(c);
                conv_out_y     = POS_W'(y);
                conv_out_x     = POS_W'(x);
                conv_out       = $urandom;
                conv_out_valid = 1'b1;
                exp_out.push_back('{c * out_dim * out_dim + y * out_dim + x, conv_out});
            end
        end
    end

    logic              prev_stall;
    logic [31:0]       held_data;
    logic [IDX_W-1:0]  held_idx;
    logic [POS_W-1:0]  held_x;
    logic [POS_W-1:0]  held_y;
    int                got_rd;
    in_item_t          got_in;
    out_item_t         got_out;

    // Monitor: pops the scoreboard whenever the DUT presents a read, input or write.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (src_rd) begin
                n_reads++;
                checkOutput("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) begin
                    got_rd = exp_rd.pop_front();
                    checkOutput("src_addr", 32'(src_addr), got_rd);
                end
            end
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(conv_in_valid), 32'd1);
                checkOutput("hold_data", conv_in, held_data);
                checkOutput("hold_coord", 32'({conv_in_idx, conv_in_y, conv_in_x}),
                            32'({held_idx, held_y, held_x}));
            end
            prev_stall = conv_in_valid && !conv_in_rdy;
            held_data  = conv_in;
            held_idx   = conv_in_idx;
            held_x     = conv_in_x;
            held_y     = conv_in_y;
            if (conv_in_valid && conv_in_rdy) begin
                checkOutput("in_expected", 32'(exp_in.size() > 0), 32'd1);
                if (exp_in.size() > 0) begin
                    got_in = exp_in.pop_front();
                    checkOutput("in_idx", 32'(conv_in_idx), got_in.idx);
                    checkOutput("in_y", 32'(conv_in_y), got_in.y);
                    checkOutput("in_x", 32'(conv_in_x), got_in.x);
                    checkOutput("in_data", conv_in, got_in.data);
                end
                last_in_idx = int'(conv_in_idx);
                last_in_y   = int'(conv_in_y);
                last_in_x   = int'(conv_in_x);
            end
            if (dst_we) begin
                n_writes++;
                checkOutput("wr_expected", 32'(exp_out.size() > 0), 32'd1);
                if (exp_out.size() > 0) begin
                    got_out = exp_out.pop_front();
                    checkOutput("dst_addr", 32'(dst_addr), got_out.addr);
                    checkOutput("dst_data", dst_data, got_out.data);
                end
            end
            if (!dst_ready) begin
                checkOutput("stall_out_rdy", 32'(conv_out_rdy), 32'd0);
                checkOutput("stall_dst_we", 32'(dst_we), 32'd0);
            end
            if (busy) checkOutput("conv_forward", 32'(conv_forward), 32'(!pass_dir));
            if (done) n_done++;
        end
    end

    task automatic applyStimulus(input bit d, input int mode, input int stall);
        int ci, di, co;
        @(negedge clk);
        ci = d ? 16 : 8;
        di = d ? 4 : 12;
        co = d ? 8 : 16;
        out_dim     = d ? 12 : 4;
        n_in_total  = ci * di * di;
        n_out_total = co * out_dim * out_dim;
        pass_dir    = d;
        exp_in.delete();
        exp_rd.delete();
        exp_out.delete();
        for (int a = 0; a < n_in_total; a++) src_mem[a] = $urandom;
        for (int c = 0; c < ci; c++)
            for (int y = 0; y < di; y++)
                for (int x = 0; x < di; x++) begin
                    exp_rd.push_back(c * di * di + y * di + x);
                    exp_in.push_back('{c, y, x, src_mem[c * di * di + y * di + x]});
                end
        in_cnt = 0; out_emitted = 0;
        n_reads = 0; n_writes = 0; n_done = 0;
        last_in_idx = -1; last_in_y = -1; last_in_x = -1;
        rdy_mode = mode; stall_at = stall; stall_left = 0; stall_done = 1'b0;
        model_active = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b1;
        dir   = d;
        @(posedge clk);
        #2;
        start = 1'b0;
        dir   = 1'($urandom_range(1));
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("first_src_rd", 32'(src_rd), 32'd1);
        checkOutput("first_src_addr", 32'(src_addr), 32'd0);
    endtask

    task automatic waitPass(input bit d, input int restart_at);
        int cyc = 0;
        while (n_done == 0 && cyc < 20000) begin
            @(posedge clk);
            #3;
            cyc++;
            if (cyc == restart_at) begin
                start = 1'b1;
                dir   = !d;
            end else if (cyc == restart_at + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(n_done > 0), 32'd1);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #3;
        checkOutput("done_pulses", 32'(n_done), 32'd1);
        checkOutput("read_count", 32'(n_reads), d ? 32'd256 : 32'd1152);
        checkOutput("write_count", 32'(n_writes), d ? 32'd1152 : 32'd256);
        checkOutput("last_in_idx", 32'(last_in_idx), d ? 32'd15 : 32'd7);
        checkOutput("last_in_y", 32'(last_in_y), d ? 32'd3 : 32'd11);
        checkOutput("last_in_x", 32'(last_in_x), d ? 32'd3 : 32'd11);
        checkOutput("in_left", 32'(exp_in.size()), 32'd0);
        checkOutput("wr_left", 32'(exp_out.size()), 32'd0);
        model_active = 1'b0;
        if (n_done == 0) begin
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #3;
            rst_n = 1'b1;
        end
    endtask

    initial begin : main
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        model_active = 1'b0;
        idle_probe   = 1'b0;
        rdy_mode = 0;
        stall_at = -1;
        repeat (3) @(posedge clk);
        #3;
        checkReset("reset");
        rst_n = 1'b1;

        idle_probe = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #3;
            checkOutput("idle_out_rdy", 32'(conv_out_rdy), 32'd0);
            checkOutput("idle_dst_we", 32'(dst_we), 32'd0);
        end
        idle_probe = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] forward pass, full rate");
        applyStimulus(1'b0, 0, -1);
        waitPass(1'b0, -10);

        $display("[TB] backward pass, full rate");
        applyStimulus(1'b1, 0, -1);
        waitPass(1'b1, -10);

        $display("[TB] forward pass, input ready toggling");
        applyStimulus(1'b0, 1, -1);
        waitPass(1'b0, -10);

        $display("[TB] forward pass, destination stall");
        applyStimulus(1'b0, 0, 100);
        waitPass(1'b0, -10);

        $display("[TB] reset at input element 500");
        applyStimulus(1'b0, 2, -1);
        cyc = 0;
        while (in_cnt < 500 && cyc < 5000) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        checkOutput("reached_500", 32'(in_cnt >= 500), 32'd1);
        rst_n = 1'b0;
        model_active = 1'b0;
        #1;
        checkReset("midreset");
        repeat (2) @(negedge clk);
        checkOutput("no_partial_done", 32'(n_done), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b0, 2, -1);
        waitPass(1'b0, -10);

        $display("[TB] backward pass, start re-asserted with flipped dir");
        applyStimulus(1'b1, 2, 50);
        waitPass(1'b1, 200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
